multicycle_controller: RTL and testbench

Control sequencer for the multi-cycle RV32I core. Walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK over a shared memory port with a req/ready handshake, and drives every datapath strobe: IR/PC write, register-file write, ALU operand selects, ALUOp, memory request/write and writeback mux. It replaces the single-cycle opcode-to-control mapping with a state machine. It also keeps a sticky illegal-instruction flag and a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared
// req/ready memory port, plus a sticky illegal-opcode flag and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [1:0]           alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           ALUOp,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [2:0]           state
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 retire;
  logic                 set_illegal;
  logic                 legal;

  always_comb begin
    case (opcode)
      OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui, OpAuipc: legal = 1'b1;
      default:                                                            legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    alu_src_a    = 2'd0;
    alu_src_b    = 1'b0;
    ALUOp        = 2'b00;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (legal) begin
          state_d = StExecute;
        end else begin
          state_d     = StTrap;
          set_illegal = 1'b1;
        end
      end
      StExecute: begin
        state_d = StWriteback;
        case (opcode)
          OpR:     ALUOp = 2'b10;
          OpI:     begin ALUOp = 2'b11; alu_src_b = 1'b1; end
          OpLui:   begin alu_src_a = 2'd2; alu_src_b = 1'b1; end
          OpAuipc: begin alu_src_a = 2'd1; alu_src_b = 1'b1; end
          OpLoad, OpStore: begin
            alu_src_b = 1'b1;
            state_d   = StMem;
          end
          OpBranch: begin
            ALUOp    = 2'b01;
            pc_write = branch_taken;
            pc_src   = 2'd1;
            state_d  = StFetch;
            retire   = 1'b1;
          end
          OpJal: begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
          end
          OpJalr: begin
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 2'd2;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        // Operand selects stay as in EXECUTE so the address is stable while waiting.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OpStore);
        alu_src_b    = 1'b1;
        if (mem_ready) begin
          if (opcode == OpStore) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        reg_write = 1'b1;
        if (opcode == OpLoad) wb_sel = 2'd1;
        else if (opcode == OpJal || opcode == OpJalr) wb_sel = 2'd2;
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap: state_d = StTrap;
      default: state_d = StFetch;
    endcase

    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'd0;
      reg_write    = 1'b0;
      wb_sel       = 2'd0;
      alu_src_a    = 2'd0;
      alu_src_b    = 1'b0;
      ALUOp        = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign state   = rst ? 3'd0 : state_q;
  assign illegal = illegal_q & ~rst;
  assign instret = rst ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench: an instruction-level model queues the expected
// per-cycle control outputs; a monitor compares them against the DUT every cycle.
module tb_multicycle_controller;

  localparam int unsigned CW = 4;  // narrow counter so wrap-around is exercised

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          branch_taken;
  logic          mem_ready;
  logic          mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, alu_src_b, illegal;
  logic [1:0]    pc_src, wb_sel, alu_src_a, ALUOp;
  logic [CW-1:0] instret;
  logic [2:0]    state;

  multicycle_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
    .illegal(illegal), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          req, we, asel, irw, pcw;
    logic [1:0]    pcsrc;
    logic          rw;
    logic [1:0]    wb, srca;
    logic          srcb;
    logic [1:0]    aluop;
    logic          ill;
    logic [CW-1:0] ret;
  } exp_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  exp_t          exp_q[$];
  string         name_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] m_ret = '0;
  logic          m_ill = 1'b0;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{st: state, req: mem_req, we: mem_we, asel: mem_addr_sel, irw: ir_write,
            pcw: pc_write, pcsrc: pc_src, rw: reg_write, wb: wb_sel, srca: alu_src_a,
            srcb: alu_src_b, aluop: ALUOp, ill: illegal, ret: instret};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
      end
    end
  end

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e = '0;
    e.st  = st;
    e.ill = m_ill;
    e.ret = m_ret;
    return e;
  endfunction

  task automatic cyc(input exp_t e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    m_ret = '0;
    m_ill = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready    = 1'($urandom);
      branch_taken = 1'($urandom);
      cyc('0, "reset_outputs");
    end
    rst = 1'b0;
  endtask

  // One instruction: FETCH with fw wait cycles, MEM with mw wait cycles.
  task automatic run_instr(input logic [6:0] op, input logic taken, input int fw, input int mw);
    exp_t e;
    logic is_wb;
    for (int w = 0; w <= fw; w++) begin
      mem_ready = (w == fw);
      opcode    = 7'($urandom);
      e = blank(3'd0);
      e.req = 1'b1;
      e.irw = mem_ready;
      e.pcw = mem_ready;
      cyc(e, "fetch");
    end
    opcode       = op;
    mem_ready    = 1'($urandom);
    branch_taken = 1'($urandom);
    cyc(blank(3'd1), "decode");
    if (!(op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})) begin
      m_ill = 1'b1;
      for (int i = 0; i < 12; i++) begin
        mem_ready = 1'($urandom);
        cyc(blank(3'd5), "trap_idle");
      end
      return;
    end
    branch_taken = taken;
    mem_ready    = 1'($urandom);
    e = blank(3'd2);
    is_wb = 1'b1;
    case (op)
      OP_R:     e.aluop = 2'b10;
      OP_I:     begin e.aluop = 2'b11; e.srcb = 1'b1; end
      OP_LUI:   begin e.srca = 2'd2; e.srcb = 1'b1; end
      OP_AUIPC: begin e.srca = 2'd1; e.srcb = 1'b1; end
      OP_LD, OP_ST: e.srcb = 1'b1;
      OP_BR:    begin e.aluop = 2'b01; e.pcw = taken; e.pcsrc = 2'd1; is_wb = 1'b0; end
      OP_JAL:   begin e.pcw = 1'b1; e.pcsrc = 2'd1; end
      default:  begin e.srcb = 1'b1; e.pcw = 1'b1; e.pcsrc = 2'd2; end
    endcase
    cyc(e, (op == OP_BR) ? "exec_branch" : "execute");
    if (op == OP_BR) begin
      m_ret++;
      return;
    end
    branch_taken = 1'($urandom);
    if (op == OP_LD || op == OP_ST) begin
      for (int w = 0; w <= mw; w++) begin
        mem_ready = (w == mw);
        e = blank(3'd3);
        e.req  = 1'b1;
        e.asel = 1'b1;
        e.we   = (op == OP_ST);
        e.srcb = 1'b1;
        cyc(e, "mem");
      end
      if (op == OP_ST) begin
        m_ret++;
        return;
      end
    end
    mem_ready = 1'($urandom);
    e = blank(3'd4);
    e.rw = 1'b1;
    e.wb = (op == OP_LD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
    cyc(e, "writeback");
    if (is_wb) m_ret++;
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    rst = 1'b1;
    opcode = '0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Directed cases.
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_LD, 1'b0, 0, 2);
    run_instr(OP_ST, 1'b0, 0, 0);
    run_instr(OP_BR, 1'b1, 0, 0);
    run_instr(OP_BR, 1'b0, 0, 0);
    run_instr(OP_JALR, 1'b0, 0, 0);
    run_instr(OP_JAL, 1'b0, 1, 0);

    // Randomized stream; counter wraps several times.
    for (int i = 0; i < 150; i++) begin
      int fw, mw;
      fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(ops[$urandom_range(0, 8)], 1'($urandom), fw, mw);
    end

    // Reset in the middle of a stalled fetch.
    mem_ready = 1'b0;
    begin
      exp_t e;
      e = blank(3'd0);
      e.req = 1'b1;
      cyc(e, "fetch_stall");
    end
    do_reset(2);
    run_instr(OP_I, 1'b0, 0, 0);

    // Illegal opcode traps, then reset recovers.
    run_instr(7'b1111111, 1'b0, 0, 0);
    do_reset(1);
    run_instr(OP_AUIPC, 1'b0, 0, 0);
    run_instr(OP_LUI, 1'b0, 2, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
